// File: rtl/rr_lock_arbiter_pkg.sv
// rtl/rr_lock_arbiter_pkg.sv - shared types and helpers for the round-robin lock arbiter
package arb_pkg;

  typedef enum logic {IDLE, GRANT} arb_state_e;

  localparam int ARB_MAX_PORTS = 32;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Caller guarantees a one-hot or zero vector, so OR-ing indices yields the position.
  function automatic int unsigned onehot_to_idx(input logic [ARB_MAX_PORTS-1:0] oh);
    int unsigned idx;
    idx = 0;
    for (int i = 0; i < ARB_MAX_PORTS; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_if.sv
// rtl/rr_lock_arbiter_if.sv - request/grant bundle between requesters and the arbiter
interface rr_lock_arbiter_if #(
  parameter int NUM_PORTS = 4
);
  localparam int IDX_W = arb_pkg::clog2_min1(NUM_PORTS);

  logic [NUM_PORTS-1:0] req_i;
  logic                 last_i;
  logic [NUM_PORTS-1:0] gnt_o;
  logic [IDX_W-1:0]     gnt_id_o;
  logic                 busy_o;
  logic                 timeout_o;

  modport master (
    output req_i, last_i,
    input  gnt_o, gnt_id_o, busy_o, timeout_o
  );

  modport slave (
    input  req_i, last_i,
    output gnt_o, gnt_id_o, busy_o, timeout_o
  );

endinterface

// File: rtl/rr_lock_arbiter_fp_pick.sv
// rtl/rr_lock_arbiter_fp_pick.sv - combinational fixed-priority pick, LSB wins
module fp_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt,
  output logic         o_any
);

  // Two's-complement trick isolates the lowest set bit.
  assign o_gnt = i_req & (~i_req + N'(1));
  assign o_any = |i_req;

endmodule

// File: rtl/rr_lock_arbiter.sv
// rtl/rr_lock_arbiter.sv - registered round-robin arbiter with grant locking and hold limit
module rr_lock_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 8
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  rr_lock_arbiter_if.slave bus
);

  localparam int IDX_W  = clog2_min1(NUM_PORTS);
  localparam int HOLD_W = clog2_min1(MAX_HOLD + 1);

  arb_state_e           r_state;
  logic [NUM_PORTS-1:0] r_gnt;
  logic [IDX_W-1:0]     r_ptr;
  logic [HOLD_W-1:0]    r_hold;
  logic                 r_timeout;

  arb_state_e           w_state_nxt;
  logic [NUM_PORTS-1:0] w_gnt_nxt;
  logic [IDX_W-1:0]     w_ptr_nxt;
  logic [HOLD_W-1:0]    w_hold_nxt;
  logic                 w_timeout_nxt;

  logic [IDX_W-1:0]     w_gnt_id;
  logic [IDX_W-1:0]     w_ptr_inc;
  logic [IDX_W-1:0]     w_arb_ptr;
  logic                 w_rel_drop;
  logic                 w_rel_last;
  logic                 w_rel_hold;
  logic                 w_release;
  logic [NUM_PORTS-1:0] w_mask;
  logic [NUM_PORTS-1:0] w_req_masked;
  logic [NUM_PORTS-1:0] w_gnt_masked;
  logic [NUM_PORTS-1:0] w_gnt_raw;
  logic                 w_any_masked;
  logic                 w_any_raw;
  logic [NUM_PORTS-1:0] w_pick;

  assign w_gnt_id   = IDX_W'(onehot_to_idx(ARB_MAX_PORTS'(r_gnt)));
  assign w_ptr_inc  = (w_gnt_id == IDX_W'(NUM_PORTS - 1)) ? '0 : w_gnt_id + IDX_W'(1);

  assign w_rel_drop = ~|(bus.req_i & r_gnt);
  assign w_rel_last = bus.last_i;
  assign w_rel_hold = (MAX_HOLD != 0) && (r_hold == HOLD_W'(MAX_HOLD));
  assign w_release  = (r_state == GRANT) && (w_rel_drop || w_rel_last || w_rel_hold);

  // Re-arbitration on release must already see the advanced pointer.
  assign w_arb_ptr  = w_release ? w_ptr_inc : r_ptr;

  always_comb begin
    w_mask = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_mask[i] = (i >= int'(w_arb_ptr));
    end
  end

  assign w_req_masked = bus.req_i & w_mask;

  fp_pick #(.N(NUM_PORTS)) u_pick_masked (
    .i_req (w_req_masked),
    .o_gnt (w_gnt_masked),
    .o_any (w_any_masked)
  );

  fp_pick #(.N(NUM_PORTS)) u_pick_raw (
    .i_req (bus.req_i),
    .o_gnt (w_gnt_raw),
    .o_any (w_any_raw)
  );

  assign w_pick = w_any_masked ? w_gnt_masked : w_gnt_raw;

  always_comb begin
    w_state_nxt   = r_state;
    w_gnt_nxt     = r_gnt;
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_timeout_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_any_raw) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = w_pick;
          w_hold_nxt  = HOLD_W'(1);
        end
      end
      GRANT: begin
        if (w_release) begin
          w_ptr_nxt     = w_ptr_inc;
          w_timeout_nxt = w_rel_hold && !w_rel_drop && !w_rel_last;
          if (w_any_raw) begin
            w_gnt_nxt  = w_pick;
            w_hold_nxt = HOLD_W'(1);
          end else begin
            w_state_nxt = IDLE;
            w_gnt_nxt   = '0;
            w_hold_nxt  = '0;
          end
        end else if (MAX_HOLD != 0 && r_hold != HOLD_W'(MAX_HOLD)) begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_ptr     <= '0;
      r_hold    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign bus.gnt_o     = r_gnt;
  assign bus.gnt_id_o  = w_gnt_id;
  assign bus.busy_o    = |r_gnt;
  assign bus.timeout_o = r_timeout;

endmodule
